// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register write arbiter.
//
// Holds the FSM state encoding, the default sizing of the arbiter and a small
// index helper shared by the top level.
package reg_arb_pkg;

  // Default number of requesters.
  localparam int N_DEFAULT        = 4;
  // Default shared register width in bits.
  localparam int W_DEFAULT        = 8;
  // Default number of HOLD cycles before a grant is forcibly released.
  localparam int MAX_HOLD_DEFAULT = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } arb_state_e;

  // Next requester index after idx, wrapping from n-1 back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_picker.sv
// Round-robin winner selection (purely combinational).
//
// Ports:
//   req     [N-1:0]  : request vector
//   ptr     [PW-1:0] : index with the highest priority this round
//   winner  [PW-1:0] : first requesting index at or above ptr, wrapping N-1 -> 0
//   any_req          : at least one request bit is set
module rr_picker
  import reg_arb_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] winner,
  output logic          any_req
);

  logic [PW-1:0] idx;

  // Walk the offsets from farthest to nearest so the last hit, which is the
  // one closest to ptr, is the one that sticks.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = PW'((int'(ptr) + off) % N);
      if (req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shared-register write arbiter.
//
// N requesters compete to write one W-bit register. A round-robin pick is made
// in IDLE, the winner is granted for one cycle (GRANT), writes the register if
// it is still requesting, and may then keep ownership (HOLD) for at most
// MAX_HOLD cycles before the grant is forcibly taken away.
//
// Ports:
//   clk              : clock, rising edge
//   rst              : asynchronous active-high reset
//   req     [N-1:0]  : level-held write requests
//   wdata   [N*W-1:0]: write data, requester i on bits [i*W +: W]
//   gnt     [N-1:0]  : one-hot registered grant
//   ack     [N-1:0]  : one-cycle write-done pulse to the writer
//   q       [W-1:0]  : shared register value
//   owner            : index of the last requester that wrote q
//   valid            : q has been written since reset
//   timeout          : one-cycle pulse on a forced release
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int W        = W_DEFAULT,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       wdata,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         ack,
  output logic [W-1:0]         q,
  output logic [$clog2(N)-1:0] owner,
  output logic                 valid,
  output logic                 timeout
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD + 1);

  arb_state_e    state_q, state_d;
  logic [PW-1:0] win_q, win_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  gnt_d;
  logic [N-1:0]  ack_d;
  logic [W-1:0]  q_d;
  logic [PW-1:0] owner_d;
  logic          valid_d;
  logic          timeout_d;

  logic [PW-1:0] pick_win;
  logic          pick_any;

  rr_picker #(
    .N  (N),
    .PW (PW)
  ) u_picker (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (pick_win),
    .any_req (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt;
    ack_d     = '0;
    q_d       = q;
    owner_d   = owner;
    valid_d   = valid;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_any) begin
          win_d           = pick_win;
          gnt_d[pick_win] = 1'b1;
          state_d         = GRANT;
        end
      end

      GRANT: begin
        if (req[win_q]) begin
          q_d          = wdata[win_q*W +: W];
          ack_d[win_q] = 1'b1;
          owner_d      = win_q;
          valid_d      = 1'b1;
          ptr_d        = PW'(wrap_inc(int'(win_q), N));
          cnt_d        = '0;
          state_d      = HOLD;
        end else begin
          // Winner dropped its request before writing: abandon without
          // advancing the round-robin pointer.
          gnt_d   = '0;
          state_d = IDLE;
        end
      end

      HOLD: begin
        // A voluntary release takes precedence over the hold limit, so a
        // requester leaving on its last allowed cycle never sees a timeout.
        if (!req[win_q]) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q >= CW'(MAX_HOLD - 1)) begin
          gnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt     <= '0;
      ack     <= '0;
      q       <= '0;
      owner   <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt     <= gnt_d;
      ack     <= ack_d;
      q       <= q_d;
      owner   <= owner_d;
      valid   <= valid_d;
      timeout <= timeout_d;
    end
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, meaning the number of requesters.
REQ-002 SHALL have parameter W, default 8, meaning the shared register width in bits.
REQ-003 SHALL have parameter MAX_HOLD, default 15, meaning the maximum number of HOLD cycles before a forced release.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port req, input, N bits: per-requester write request, level-held.
REQ-007 SHALL have port wdata, input, N*W bits: flattened write data; requester i uses bits [i*W +: W].
REQ-008 SHALL have port gnt, output, N bits: one-hot registered grant.
REQ-009 SHALL have port ack, output, N bits: one-cycle write-done pulse to the winning requester.
REQ-010 SHALL have port q, output, W bits: the shared register value.
REQ-011 SHALL have port owner, output, clog2(N) bits: the index of the last requester that wrote q.
REQ-012 SHALL have port valid, output, 1 bit: high once q has been written at least once since reset.
REQ-013 SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is forcibly released.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT and HOLD; all outputs are registered.
REQ-015 In IDLE with req != 0, SHALL select the winner round-robin, searching upward from pointer ptr with wrap-around (N-1 -> 0), set gnt to onehot(winner), and go to GRANT.
REQ-016 In IDLE with req == 0, SHALL keep gnt = 0 and remain in IDLE.
REQ-017 In GRANT with req[winner] = 1, SHALL load q <= wdata[winner], pulse ack[winner] for one cycle, set owner <= winner, set valid <= 1, set ptr <= (winner+1) mod N, and go to HOLD.
REQ-018 In GRANT with req[winner] = 0, SHALL abort: no write, no ack, ptr unchanged, gnt <= 0, next state IDLE.
REQ-019 SHALL have latency as follows: req sampled at edge k gives gnt at edge k+1, and q update plus ack at edge k+2.
REQ-020 In HOLD, SHALL keep gnt asserted while req[winner] = 1; when req[winner] = 0, gnt <= 0 and the FSM goes to IDLE.
REQ-021 SHALL count HOLD cycles; on reaching MAX_HOLD with req[winner] still high, SHALL set gnt <= 0, pulse timeout, and go to IDLE.
REQ-022 After a forced release, the same requester SHALL compete again only through round-robin from the updated ptr.
REQ-023 Requests arriving during GRANT or HOLD SHALL be ignored until the next IDLE cycle; requests carry no sticky state.
REQ-024 The minimum transaction SHALL be 3 cycles (IDLE, GRANT, HOLD), giving at most one write per 3 cycles.
REQ-025 q SHALL change only in GRANT on a non-aborted transaction and SHALL hold its value otherwise.
REQ-026 ack, gnt and timeout SHALL never assert more than one bit or pulse simultaneously; ack and timeout SHALL never be high in the same cycle.

Reset
REQ-027 While rst = 1, SHALL immediately force state = IDLE, q = 0, gnt = 0, ack = 0, owner = 0, valid = 0, timeout = 0, ptr = 0 and hold counter = 0, independent of clk.
REQ-028 A reset asserted mid-GRANT or mid-HOLD SHALL discard the transaction with no ack; operation resumes from IDLE on the first edge after rst falls.

Structure
REQ-029 SHALL place the state encoding (IDLE = 0, GRANT = 1, HOLD = 2) and the defaults for N, W and MAX_HOLD in the shared package reg_arb_pkg.
REQ-030 SHALL implement the winner selection in a combinational sub-module rr_picker (inputs req and ptr; outputs winner index and any_req).

Verification
REQ-031 Reset: rst = 1 for 100 ns, toggling req = 4'b1111 -> all outputs 0; after release the first grant goes to requester 0.
REQ-032 Single write: req[2] = 1 with wdata[2] = 8'hA5 at edge k -> gnt = 4'b0100 at k+1; q = 8'hA5, ack = 4'b0100, owner = 2, valid = 1 at k+2; drop req -> gnt = 0.
REQ-033 Fairness: req = 4'b1111 held, each requester dropping req on its ack -> grant order 0, 1, 2, 3, 0, with q following wdata each time.
REQ-034 Abort: req[1] deasserted in the GRANT cycle -> no ack, q unchanged, ptr unchanged, next grant goes again to requester 1 when it re-requests.
REQ-035 Timeout: req[3] held high indefinitely -> timeout pulses after 15 HOLD cycles, gnt = 0, and pending req[0] is then granted.
REQ-036 Async reset mid-HOLD: rst pulse between clock edges -> q = 0 and gnt = 0 immediately, without waiting for a clk edge.
